// File: rtl/uart_mem_ctrl.sv
// rtl/uart_mem_ctrl.sv - UART command frame sequencer for a 256x8 byte memory
// Optional inter-byte timeout is enabled by defining UART_MEM_CTRL_TIMEOUT_EN.
module uart_mem_ctrl #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_write_byte,
  input  logic [7:0] mem_read_byte,
  output logic       busy,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_DO_WRITE, S_DO_READ, S_WAIT_READ, S_SEND
  } state_t;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;

  state_t     r_state;
  state_t     w_next;
  logic       w_error;
  logic       w_timeout;
  logic       w_opcode_ok;
  logic       r_op_w;
  logic [1:0] r_cnt;
  logic [7:0] r_tx_byte;
  logic       r_tx_valid;
  logic       r_mem_read;
  logic       r_mem_write;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_write_byte;
  logic       r_busy;
  logic       r_error;

  assign w_opcode_ok = (rx_byte == OP_W) || (rx_byte == OP_R);

`ifdef UART_MEM_CTRL_TIMEOUT_EN
  logic [15:0] r_gap;
  logic        w_in_get;

  assign w_in_get  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
  assign w_timeout = w_in_get && (r_gap == 16'(TIMEOUT_CYCLES));

  // Held at zero outside the frame-gathering states, so entry always starts from 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gap <= 16'd0;
    end else if (!w_in_get || w_timeout || rx_valid) begin
      r_gap <= 16'd0;
    end else begin
      r_gap <= r_gap + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_error = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (w_opcode_ok) w_next = S_GET_ADDR;
          else             w_error = 1'b1;
        end
      end
      S_GET_ADDR: begin
        if (w_timeout) begin
          w_next  = S_IDLE;
          w_error = 1'b1;
        end else if (rx_valid) begin
          w_next = r_op_w ? S_GET_DATA : S_DO_READ;
        end
      end
      S_GET_DATA: begin
        if (w_timeout) begin
          w_next  = S_IDLE;
          w_error = 1'b1;
        end else if (rx_valid) begin
          w_next = S_DO_WRITE;
        end
      end
      S_DO_WRITE: begin
        w_next  = S_IDLE;
        w_error = rx_valid;
      end
      S_DO_READ: begin
        w_next  = S_WAIT_READ;
        w_error = rx_valid;
      end
      S_WAIT_READ: begin
        if (r_cnt == 2'd0) w_next = S_SEND;
        w_error = rx_valid;
      end
      S_SEND: begin
        if (tx_ready) w_next = S_IDLE;
        w_error = rx_valid;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Every output is a register derived from the next state, so strobes line up with their state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_op_w           <= 1'b0;
      r_cnt            <= 2'd0;
      r_tx_byte        <= 8'h00;
      r_tx_valid       <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_addr       <= 8'h00;
      r_mem_write_byte <= 8'h00;
      r_busy           <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_error     <= w_error;
      r_busy      <= (w_next != S_IDLE);
      r_mem_write <= (w_next == S_DO_WRITE);
      r_mem_read  <= (w_next == S_DO_READ);
      r_tx_valid  <= (w_next == S_SEND);
      if (r_state == S_IDLE && rx_valid && w_opcode_ok) begin
        r_op_w <= (rx_byte == OP_W);
      end
      if (r_state == S_GET_ADDR && rx_valid && !w_timeout) begin
        r_mem_addr <= rx_byte;
      end
      if (r_state == S_GET_DATA && rx_valid && !w_timeout) begin
        r_mem_write_byte <= rx_byte;
      end
      if (r_state == S_DO_READ) begin
        r_cnt <= 2'(READ_LATENCY - 1);
      end else if (r_state == S_WAIT_READ && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (r_state == S_WAIT_READ && r_cnt == 2'd0) begin
        r_tx_byte <= mem_read_byte;
      end
    end
  end

  assign tx_byte        = r_tx_byte;
  assign tx_valid       = r_tx_valid;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_addr       = r_mem_addr;
  assign mem_write_byte = r_mem_write_byte;
  assign busy           = r_busy;
  assign error          = r_error;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb/tb_uart_mem_ctrl.sv - directed self-checking bench for uart_mem_ctrl
// dut1 uses READ_LATENCY=1; dut3 uses READ_LATENCY=3 and TIMEOUT_CYCLES=20.
module tb_uart_mem_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sel;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_ready;

  logic [7:0] tx_byte1, mem_addr1, mem_write_byte1, mem_read_byte1;
  logic       tx_valid1, mem_read1, mem_write1, busy1, error1;
  logic [7:0] tx_byte3, mem_addr3, mem_write_byte3, mem_read_byte3;
  logic       tx_valid3, mem_read3, mem_write3, busy3, error3;

  int total = 0;
  int bad   = 0;
  int wr_count1 = 0;
  int snap;
  int err_seen;

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] p1_d;
  logic       p1_v;
  logic [7:0] p3_d [3];
  logic [2:0] p3_v;

  always #5 clock = ~clock;

  uart_mem_ctrl #(.READ_LATENCY(1), .TIMEOUT_CYCLES(1000)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid & ~sel),
    .tx_byte(tx_byte1), .tx_valid(tx_valid1), .tx_ready(tx_ready & ~sel),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_write_byte(mem_write_byte1), .mem_read_byte(mem_read_byte1),
    .busy(busy1), .error(error1)
  );

  uart_mem_ctrl #(.READ_LATENCY(3), .TIMEOUT_CYCLES(20)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid & sel),
    .tx_byte(tx_byte3), .tx_valid(tx_valid3), .tx_ready(tx_ready & sel),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
    .mem_write_byte(mem_write_byte3), .mem_read_byte(mem_read_byte3),
    .busy(busy3), .error(error3)
  );

  // Memory models: read data is only meaningful in the exact latency cycle, 0x5A otherwise.
  assign mem_read_byte1 = p1_v ? p1_d : 8'h5A;
  assign mem_read_byte3 = p3_v[2] ? p3_d[2] : 8'h5A;

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 8'(i) ^ 8'h3C;
        mem3[i] <= 8'(i) ^ 8'h3C;
      end
      p1_v <= 1'b0;
      p1_d <= 8'h00;
      p3_v <= 3'b000;
      for (int i = 0; i < 3; i++) p3_d[i] <= 8'h00;
    end else begin
      if (mem_write1) mem1[mem_addr1] <= mem_write_byte1;
      if (mem_write3) mem3[mem_addr3] <= mem_write_byte3;
      p1_d    <= mem1[mem_addr1];
      p1_v    <= mem_read1;
      p3_d[0] <= mem3[mem_addr3];
      p3_d[1] <= p3_d[0];
      p3_d[2] <= p3_d[1];
      p3_v    <= {p3_v[1:0], mem_read3};
    end
  end

  always @(posedge clock) begin
    if (mem_write1) wr_count1 <= wr_count1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    sel      = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) tick();

    check("rst_tx_byte", tx_byte1, 8'h00);
    check("rst_tx_valid", tx_valid1, 1'b0);
    check("rst_mem_addr", mem_addr1, 8'h00);
    check("rst_busy", busy1, 1'b0);
    check("rst_strobes", {mem_read1, mem_write1, error1}, 3'b000);
    reset_n = 1'b1;
    tick();

    // Write frame
    send(8'h57);
    check("w_busy_after_op", busy1, 1'b1);
    check("w_no_error", error1, 1'b0);
    send(8'h0A);
    check("w_no_strobe_early", mem_write1, 1'b0);
    send(8'h07);
    check("w_strobe", mem_write1, 1'b1);
    check("w_addr", mem_addr1, 8'h0A);
    check("w_data", mem_write_byte1, 8'h07);
    check("w_no_read", mem_read1, 1'b0);
    tick();
    check("w_strobe_end", mem_write1, 1'b0);
    check("w_busy_end", busy1, 1'b0);

    // Read back with latency 1
    send(8'h52);
    send(8'h0A);
    check("r_strobe", mem_read1, 1'b1);
    check("r_addr", mem_addr1, 8'h0A);
    check("r_no_write", mem_write1, 1'b0);
    tick();
    check("r_strobe_end", mem_read1, 1'b0);
    check("r_wait_no_valid", tx_valid1, 1'b0);
    tick();
    check("r_tx_valid", tx_valid1, 1'b1);
    check("r_tx_byte", tx_byte1, 8'h07);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r_hold", {tx_valid1, tx_byte1}, {1'b1, 8'h07});
    end

    // Overrun during SEND
    send(8'h00);
    check("ovr_error", error1, 1'b1);
    check("ovr_tx_hold", {tx_valid1, tx_byte1}, {1'b1, 8'h07});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("r_tx_valid_clear", tx_valid1, 1'b0);
    check("r_busy_clear", busy1, 1'b0);
    check("ovr_error_pulse", error1, 1'b0);

    // Bad opcode
    send(8'h41);
    check("bad_op_error", error1, 1'b1);
    check("bad_op_busy", busy1, 1'b0);
    tick();
    check("bad_op_pulse_end", error1, 1'b0);

    // Reset mid-frame
    snap = wr_count1;
    send(8'h57);
    send(8'h10);
    check("mid_busy", busy1, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_async_busy", busy1, 1'b0);
    check("mid_rst_async_addr", mem_addr1, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
    send(8'h33);
    check("mid_err_after_rst", error1, 1'b1);
    check("mid_outs", {busy1, tx_valid1, mem_read1, mem_write1}, 4'b0000);
    check("mid_bytes", {tx_byte1, mem_addr1, mem_write_byte1}, 24'h000000);
    repeat (3) tick();
    check("mid_no_write", wr_count1, snap);

    // Latency 3 on dut3
    sel = 1'b1;
    send(8'h57);
    send(8'hFF);
    send(8'hA5);
    check("l3_write", {mem_write3, mem_addr3, mem_write_byte3}, {1'b1, 8'hFF, 8'hA5});
    tick();
    send(8'h52);
    send(8'hFF);
    check("l3_read_strobe", {mem_read3, mem_addr3}, {1'b1, 8'hFF});
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("l3_wait", tx_valid3, 1'b0);
    end
    tick();
    check("l3_tx_valid", tx_valid3, 1'b1);
    check("l3_tx_byte", tx_byte3, 8'hA5);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("l3_done", {tx_valid3, busy3}, 2'b00);

    // Inter-byte gap
    snap = 0;
    send(8'h57);
    send(8'h01);
    err_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (error3) err_seen++;
      if (mem_write3) snap++;
    end
`ifdef UART_MEM_CTRL_TIMEOUT_EN
    check("to_error_once", err_seen, 1);
    check("to_idle", busy3, 1'b0);
    check("to_no_write", snap, 0);
    send(8'h52);
    send(8'h01);
    check("to_read_strobe", {mem_read3, mem_addr3}, {1'b1, 8'h01});
    repeat (4) tick();
    check("to_read_data", {tx_valid3, tx_byte3}, {1'b1, 8'h3D});
`else
    check("gap_no_error", err_seen, 0);
    check("gap_still_busy", busy3, 1'b1);
    send(8'h5B);
    check("gap_write", {mem_write3, mem_addr3, mem_write_byte3}, {1'b1, 8'h01, 8'h5B});
    tick();
    send(8'h52);
    send(8'h01);
    check("gap_read_strobe", {mem_read3, mem_addr3}, {1'b1, 8'h01});
    repeat (4) tick();
    check("gap_read_data", {tx_valid3, tx_byte3}, {1'b1, 8'h5B});
`endif
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("final_idle", {tx_valid3, busy3}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
